// File: rtl/romulus_blk_ctrl.sv
// Control sequencer for one Romulus-N block-cipher call feeding mode_top.
// Runs four phases: load beats, SKINNY double rounds, counter update, unload beats.
`timescale 1ns/1ps
module romulus_blk_ctrl #(
    parameter int NROUNDS_X2 = 28,
    parameter int NBEATS     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       first,
    input  logic       ad_blk,
    input  logic [7:0] domain_in,
    input  logic [3:0] decrypt_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       srst,
    output logic       senc,
    output logic       sse,
    output logic       xrst,
    output logic       xenc,
    output logic       xse,
    output logic       yrst,
    output logic       yenc,
    output logic       yse,
    output logic       zrst,
    output logic       zenc,
    output logic       zse,
    output logic       erst,
    output logic       correct_cnt,
    output logic       tk1s,
    output logic [7:0] domain,
    output logic [3:0] decrypt,
    output logic [5:0] constant,
    output logic [5:0] constant2
);

    localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int RW = (NROUNDS_X2 > 1) ? $clog2(NROUNDS_X2) : 1;
    localparam logic [BW-1:0] LAST_BEAT  = BW'(NBEATS - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NROUNDS_X2 - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, CNT, UNLOAD} state_t;

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [RW-1:0] round_cnt;
    logic [5:0]    rc;
    logic          accept;
    logic          load_beat;
    logic          unload_beat;

    // One SKINNY round-constant LFSR step; two steps are consumed per cycle.
    function automatic logic [5:0] lfsr_step(input logic [5:0] r);
        return {r[4:0], r[5] ^ r[4] ^ 1'b1};
    endfunction

    assign accept      = (state == IDLE) && start;
    assign load_beat   = (state == LOAD) && in_valid;
    assign unload_beat = (state == UNLOAD) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            round_cnt <= '0;
            rc        <= 6'h01;
            tk1s      <= 1'b0;
            domain    <= 8'h00;
            decrypt   <= 4'h0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        beat_cnt  <= '0;
                        round_cnt <= '0;
                        rc        <= 6'h01;
                        tk1s      <= ad_blk;
                        domain    <= domain_in;
                        decrypt   <= decrypt_in;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= ROUND;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ROUND: begin
                    rc <= lfsr_step(lfsr_step(rc));
                    if (round_cnt == LAST_ROUND) begin
                        round_cnt <= '0;
                        state     <= CNT;
                    end else begin
                        round_cnt <= round_cnt + 1'b1;
                    end
                end
                CNT: begin
                    state <= UNLOAD;
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                            done     <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == UNLOAD);

    // Clears fire only while a start is being accepted; Z keeps its counter unless this is the first block.
    assign srst = accept;
    assign xrst = accept;
    assign yrst = accept;
    assign erst = accept;
    assign zrst = accept && first;

    assign sse  = load_beat || unload_beat;
    assign xse  = load_beat;
    assign yse  = load_beat;
    assign senc = (state == ROUND);
    assign xenc = (state == ROUND);
    assign yenc = (state == ROUND);
    assign zenc = (state == ROUND);
    assign zse         = (state == CNT);
    assign correct_cnt = (state == CNT);

    assign constant  = rc;
    assign constant2 = lfsr_step(rc);

endmodule

// File: tb/tb_romulus_blk_ctrl.sv
// Scoreboard bench for romulus_blk_ctrl: stimulus queues expected per-call behaviour,
// a negedge monitor pops and compares as the DUT accepts, rounds and completes.
`timescale 1ns/1ps
module tb_romulus_blk_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       first = 1'b0;
    logic       ad_blk = 1'b0;
    logic [7:0] domain_in = 8'h00;
    logic [3:0] decrypt_in = 4'h0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, busy, done;
    logic       srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse;
    logic       zrst, zenc, zse, erst, correct_cnt, tk1s;
    logic [7:0] domain;
    logic [3:0] decrypt;
    logic [5:0] constant, constant2;

    romulus_blk_ctrl #(.NROUNDS_X2(28), .NBEATS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first(first), .ad_blk(ad_blk),
        .domain_in(domain_in), .decrypt_in(decrypt_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done),
        .srst(srst), .senc(senc), .sse(sse),
        .xrst(xrst), .xenc(xenc), .xse(xse),
        .yrst(yrst), .yenc(yenc), .yse(yse),
        .zrst(zrst), .zenc(zenc), .zse(zse),
        .erst(erst), .correct_cnt(correct_cnt), .tk1s(tk1s),
        .domain(domain), .decrypt(decrypt),
        .constant(constant), .constant2(constant2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       zrst;
        logic       tk1s;
        logic [7:0] dom;
        logic [3:0] dec;
        int         latency;
    } call_exp_t;

    call_exp_t   q_call[$];
    logic [11:0] q_const[$];
    int total = 0;
    int bad = 0;

    // SKINNY round constants for rounds 0..55, hand-tabulated.
    logic [5:0] rc_tab [0:55] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
        6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
        6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
        6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A,
        6'h34, 6'h29, 6'h12, 6'h24, 6'h08, 6'h11, 6'h22, 6'h04, 6'h09, 6'h13,
        6'h26, 6'h0C, 6'h19, 6'h32, 6'h25, 6'h0A
    };

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor state for the call in flight.
    bit        active = 0;
    call_exp_t cur;
    int        cyc, n_load, n_round, n_cnt, n_unload, held_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
            q_call.delete();
            q_const.delete();
        end else begin
            if (active) begin
                cyc++;
                if (done) begin
                    checkOutput("done_latency", cyc, cur.latency);
                    checkOutput("load_beats", n_load, 4);
                    checkOutput("round_cycles", n_round, 28);
                    checkOutput("cnt_cycles", n_cnt, 1);
                    checkOutput("unload_beats", n_unload, 4);
                    checkOutput("held_value_errs", held_err, 0);
                    checkOutput("held_domain", {24'h0, domain}, {24'h0, cur.dom});
                    checkOutput("held_decrypt", {28'h0, decrypt}, {28'h0, cur.dec});
                    active = 0;
                end else begin
                    if (senc) begin
                        n_round++;
                        if (q_const.size() == 0) begin
                            total++; bad++;
                            $display("[TB] FAIL round_const: got unexpected round cycle, want none");
                        end else begin
                            checkOutput("round_const", {20'h0, constant, constant2}, {20'h0, q_const.pop_front()});
                        end
                    end
                    if (sse && in_ready) n_load++;
                    if (sse && out_valid) n_unload++;
                    if (zse) begin
                        n_cnt++;
                        checkOutput("cnt_correct", correct_cnt, 1);
                    end
                    if (tk1s !== cur.tk1s || domain !== cur.dom || decrypt !== cur.dec) held_err++;
                end
            end else if (done) begin
                checkOutput("unexpected_done", done, 0);
            end
            if (!busy && start) begin
                if (q_call.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL accept: got unexpected start accept, want none");
                end else begin
                    cur = q_call.pop_front();
                    checkOutput("accept_zrst", zrst, cur.zrst);
                    checkOutput("accept_clears", {srst, xrst, yrst, erst}, 4'hF);
                    active = 1; cyc = 0; n_load = 0; n_round = 0;
                    n_cnt = 0; n_unload = 0; held_err = 0;
                end
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_constants"}, {constant, constant2}, {6'h01, 6'h03});
        checkOutput({tag, "_strobes"},
            {srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse,
             erst, correct_cnt, done, in_ready, out_valid, tk1s}, 0);
        checkOutput({tag, "_held"}, {domain, decrypt}, 0);
    endtask

    // One call: in_pat is read LSB-first as in_valid per LOAD cycle.
    task automatic applyStimulus(input logic f, input logic ad, input logic [7:0] dom,
                                 input logic [3:0] dec, input logic [15:0] in_pat,
                                 input int out_stall, input bit poke_start,
                                 input int abort_at, input int latency);
        call_exp_t e;
        int beats, i, guard;
        e.zrst = f; e.tk1s = ad; e.dom = dom; e.dec = dec; e.latency = latency;
        q_call.push_back(e);
        for (int k = 0; k < 28; k++) q_const.push_back({rc_tab[2*k], rc_tab[2*k+1]});
        @(posedge clk); #1;
        start = 1; first = f; ad_blk = ad; domain_in = dom; decrypt_in = dec;
        @(posedge clk); #1;
        start = 0;
        beats = 0; i = 0;
        while (beats < 4 && i < 64) begin
            in_valid = (i < 16) ? in_pat[i] : 1'b1;
            if (in_valid) beats++;
            else begin
                @(negedge clk);
                checkOutput("load_stall_sse", {sse, xse, yse}, 0);
            end
            i++;
            @(posedge clk); #1;
        end
        in_valid = 0;
        checkOutput("round_after_load", senc, 1);
        if (abort_at >= 0) begin
            repeat (abort_at) begin @(posedge clk); #1; end
            rst_n = 0;
            #1;
            checkResetState("abort");
            repeat (2) @(posedge clk);
            #1 rst_n = 1;
            @(negedge clk);
            checkOutput("abort_no_done", {busy, done}, 0);
            return;
        end
        if (poke_start) begin
            repeat (5) begin @(posedge clk); #1; end
            start = 1; first = 1;
            @(negedge clk);
            checkOutput("ignored_start_clears", {srst, zrst}, 0);
            @(posedge clk); #1;
            start = 0; first = f;
        end
        guard = 0;
        while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
        if (!out_valid) begin
            total++; bad++;
            $display("[TB] FAIL unload_wait: got no out_valid, want out_valid within 100 cycles");
        end
        repeat (out_stall) begin
            out_ready = 0;
            @(negedge clk);
            checkOutput("unload_stall", {out_valid, sse}, 2'b10);
            @(posedge clk); #1;
        end
        out_ready = 1;
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 0;
        checkOutput("done_pulse", {busy, done}, 2'b01);
        @(posedge clk); #1;
        checkOutput("done_one_cycle", done, 0);
    endtask

    initial begin
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        checkResetState("reset");
        $display("[TB] nominal call");
        applyStimulus(1'b1, 1'b0, 8'h08, 4'h0, 16'hFFFF, 0, 1'b0, -1, 38);
        $display("[TB] load back-pressure");
        applyStimulus(1'b1, 1'b0, 8'h04, 4'h3, 16'b1011001, 0, 1'b0, -1, 41);
        $display("[TB] unload back-pressure");
        applyStimulus(1'b0, 1'b0, 8'h05, 4'hF, 16'hFFFF, 5, 1'b0, -1, 43);
        $display("[TB] start during ROUND, AD block");
        applyStimulus(1'b0, 1'b1, 8'h0C, 4'hA, 16'hFFFF, 0, 1'b1, -1, 38);
        $display("[TB] reset mid-call");
        applyStimulus(1'b1, 1'b1, 8'h0D, 4'h6, 16'hFFFF, 0, 1'b0, 10, 0);
        $display("[TB] call after reset");
        applyStimulus(1'b1, 1'b0, 8'h08, 4'h1, 16'hFFFF, 0, 1'b0, -1, 38);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, want finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
